// File: rtl/expression_result_unpacker.sv
// Unpacks a 90-bit expression result word into its 18 typed fields, one per
// handshake, with a per-word running signed sum and a completed-word counter.
module expression_result_unpacker #(
    parameter int OUT_W = 8,
    parameter int SUM_W = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [89:0]      in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_idx,
    output logic [OUT_W-1:0] out_data,
    output logic             out_signed,
    output logic             out_last,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t state, state_next;

    logic [89:0]      word;
    logic [4:0]       idx;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       width;
    logic             sgn;
    logic             fill;
    logic             emit;
    logic             at_last;
    logic             take;
    logic             load;
    logic [OUT_W-1:0] data_ext;
    logic [SUM_W-1:0] term_ext;
    logic [SUM_W-1:0] sum_next;

    // The current field always sits left-aligned at the top of the shift register.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        width = 3'd6;
        unique case (idx)
            5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15: width = 3'd4;
            5'd1, 5'd4, 5'd7, 5'd10, 5'd13, 5'd16: width = 3'd5;
            default: width = 3'd6;
        endcase
    end

    assign sgn  = idx inside {5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17};
    assign fill = sgn & word[89];

    always_comb begin
        data_ext = {OUT_W{fill}};
        term_ext = {SUM_W{fill}};
        unique case (width)
            3'd4: begin
                data_ext[3:0] = word[89:86];
                term_ext[3:0] = word[89:86];
            end
            3'd5: begin
                data_ext[4:0] = word[89:85];
                term_ext[4:0] = word[89:85];
            end
            default: begin
                data_ext[5:0] = word[89:84];
                term_ext[5:0] = word[89:84];
            end
        endcase
    end

    assign sum_next = acc + term_ext;

    assign emit    = (state == EMIT);
    assign at_last = (idx == 5'd17);
    assign take    = emit & out_ready;

    assign in_ready = ~emit | (at_last & out_ready);
    assign load     = in_valid & in_ready;

    // Field outputs are forced to zero whenever nothing is being presented.
    assign out_valid  = emit;
    assign out_idx    = emit ? idx : 5'd0;
    assign out_data   = emit ? data_ext : '0;
    assign out_signed = emit & sgn;
    assign out_last   = emit & at_last;
    assign out_sum    = emit ? sum_next : '0;
    assign word_cnt   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (take && at_last && !in_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the word register is a plain register, not a memory, so it is reset like the rest.
            word <= '0;
            idx  <= '0;
            acc  <= '0;
        end else if (load) begin
            word <= in_y;
            idx  <= '0;
            acc  <= '0;
        end else if (take && !at_last) begin
            idx <= idx + 5'd1;
            acc <= sum_next;
            unique case (width)
                3'd4:    word <= {word[85:0], 4'b0};
                3'd5:    word <= {word[84:0], 5'b0};
                default: word <= {word[83:0], 6'b0};
            endcase
        end
    end

    // A word counts only once its final field has been handed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (take && at_last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_expression_result_unpacker.sv
// Scoreboard bench for expression_result_unpacker: a field-level reference
// model queues expected beats on word acceptance, a monitor checks every cycle.
module tb_expression_result_unpacker;

    localparam int OUT_W = 8;
    localparam int SUM_W = 12;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [89:0]      in_y;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_idx;
    logic [OUT_W-1:0] out_data;
    logic             out_signed;
    logic             out_last;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] word_cnt;

    expression_result_unpacker #(
        .OUT_W(OUT_W),
        .SUM_W(SUM_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_signed(out_signed),
        .out_last  (out_last),
        .out_sum   (out_sum),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]       idx;
        logic [OUT_W-1:0] data;
        logic             sgn;
        logic             last;
        logic [SUM_W-1:0] sum;
    } beat_t;

    beat_t q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    model_cnt   = 0;
    int    run_len     = 0;
    int    last_run    = 0;
    bit    bp_en       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slice fields by their declared widths and add as integers.
    function automatic void push_word(input logic [89:0] w);
        int    off = 0;
        int    acc = 0;
        beat_t b;
        for (int k = 0; k < 18; k++) begin
            int          wv;
            int          raw;
            int          val;
            bit          s;
            logic [89:0] t;
            wv  = 4 + (k % 3);
            s   = ((k / 3) % 2) == 1;
            t   = w >> (90 - off - wv);
            raw = int'(t[5:0]) & ((1 << wv) - 1);
            val = (s && raw >= (1 << (wv - 1))) ? raw - (1 << wv) : raw;
            acc += val;
            b.idx  = 5'(k);
            b.data = OUT_W'(val);
            b.sgn  = s;
            b.last = (k == 17);
            b.sum  = SUM_W'(acc);
            q.push_back(b);
            off += wv;
        end
    endfunction

    // Monitor: compares outputs against the queue head on every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            model_cnt = 0;
            run_len   = 0;
        end else begin
            logic exp_rdy;
            check("word_cnt", 32'(word_cnt), 32'(CNT_W'(model_cnt)));
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() == 0) exp_rdy = 1'b1;
            else               exp_rdy = q[0].last & out_ready;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (out_valid && q.size() > 0) begin
                check("out_idx", 32'(out_idx), 32'(q[0].idx));
                check("out_data", 32'(out_data), 32'(q[0].data));
                check("out_signed", 32'(out_signed), 32'(q[0].sgn));
                check("out_last", 32'(out_last), 32'(q[0].last));
                check("out_sum", 32'(out_sum), 32'(q[0].sum));
                if (out_ready) begin
                    if (q[0].last) model_cnt++;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) push_word(in_y);
            if (out_valid) begin
                run_len++;
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [89:0] rand_word();
        return {26'($urandom), $urandom, $urandom};
    endfunction

    // Returns just after a posedge so stimulus never changes on a sampling edge.
    task automatic send(input logic [89:0] w, input bit keep);
        bit ok = 1'b0;
        in_y     = w;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] cnt_before;
        bit               ok;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_signed", 32'(out_signed), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-word at idx 7, then a fresh word from idx 0.
        out_ready = 1'b1;
        send(rand_word(), 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid && out_idx == 5'd7) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idx7_timeout", 32'd0, 32'd1);
        cnt_before = word_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_word_cnt", 32'(word_cnt), 32'(cnt_before));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(rand_word(), 1'b0);
        wait_idle();

        // Directed words: all zeros, all ones, only y5 at its most negative value.
        send('0, 1'b0);
        wait_idle();
        check("cnt_after_zero", 32'(word_cnt), 32'd2);
        send({90{1'b1}}, 1'b0);
        wait_idle();
        send(90'd1 << 65, 1'b0);
        wait_idle();

        // Backpressure over two words.
        bp_en = 1'b1;
        send(rand_word(), 1'b0);
        send(rand_word(), 1'b0);
        bp_en = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Three words streamed back-to-back must give one unbroken 54-cycle run.
        cnt_before = word_cnt;
        send(rand_word(), 1'b1);
        send(rand_word(), 1'b1);
        send(rand_word(), 1'b0);
        wait_idle();
        check("b2b_run_len", 32'(last_run), 32'd54);
        check("b2b_word_cnt", 32'(word_cnt), 32'(cnt_before + 3));

        // Random traffic with random gaps and backpressure.
        bp_en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(rand_word(), 1'b0);
        end
        bp_en = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("q_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
